// File: rtl/bed_thermal_pkg.sv
// Shared types and constants for the bed heater guard.
// States, fault codes and temperature width.
package bed_thermal_pkg;

  localparam int TEMP_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEATING = 2'd1,
    ST_HOLDING = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [2:0] FAULT_NONE     = 3'd0;
  localparam logic [2:0] FAULT_OVERTEMP = 3'd1;
  localparam logic [2:0] FAULT_SENSOR   = 3'd2;
  localparam logic [2:0] FAULT_TIMEOUT  = 3'd3;
  localparam logic [2:0] FAULT_RUNAWAY  = 3'd4;

endpackage

// File: rtl/bed_runaway_monitor.sv
// Thermal-runaway detector: checks the temperature rise over each
// window of valid samples and pulses when it is too small.
module bed_runaway_monitor
  import bed_thermal_pkg::*;
#(
  parameter int unsigned SAMPLES = 64,
  parameter int unsigned DELTA   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp_value,
  output logic              runaway
);

  localparam int CW = $clog2(SAMPLES + 1);

  logic [CW-1:0]     r_cnt;
  logic [TEMP_W-1:0] r_start;
  logic              w_last;
  logic [TEMP_W-1:0] w_rise;

  assign w_last = (r_cnt == CW'(SAMPLES - 1));

  // A falling temperature counts as no rise at all
  assign w_rise = (temp_value > r_start) ? (temp_value - r_start) : '0;

  assign runaway = temp_valid && !restart && w_last &&
                   (w_rise < TEMP_W'(DELTA));

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_cnt   <= '0;
      r_start <= '0;
    end else if (temp_valid) begin
      if (r_cnt == '0)
        r_start <= temp_value;
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bed_thermal_guard.sv
// Bed heater bang-bang controller with latched thermal protection
// (over-temp, sensor, sample timeout, runaway).
module bed_thermal_guard
  import bed_thermal_pkg::*;
#(
  parameter int unsigned SAMPLE_TIMEOUT  = 1_000_000,
  parameter int unsigned HYST            = 4,
  parameter int unsigned RUNAWAY_SAMPLES = 64,
  parameter int unsigned RUNAWAY_DELTA   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TEMP_W-1:0] max_temp,
  input  logic [TEMP_W-1:0] target_temp,
  input  logic              enable,
  input  logic              fault_clear,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp_value,
  output logic              heater_on,
  output logic              fault,
  output logic [2:0]        fault_code,
  output logic [1:0]        state,
  output logic              at_target
);

  localparam int WD_W = $clog2(SAMPLE_TIMEOUT + 1);

  state_t            r_state, w_state_n;
  logic              r_heater, w_heater_n;
  logic              r_fault;
  logic [2:0]        r_code, w_code_n;
  logic              r_at, w_at_n;
  logic [WD_W-1:0]   r_wd, w_wd_n;

  logic [TEMP_W-1:0] w_tgt_eff;
  logic [TEMP_W-1:0] w_lo;
  logic              w_cfg;
  logic              w_sensor;
  logic              w_over;
  logic              w_runaway;
  logic              w_restart;
  logic [2:0]        w_cause;

  assign w_cfg     = (max_temp != '0);
  assign w_tgt_eff = (target_temp < max_temp) ? target_temp
                                              : max_temp - TEMP_W'(1);
  assign w_lo      = (w_tgt_eff < TEMP_W'(HYST)) ? '0
                                                 : w_tgt_eff - TEMP_W'(HYST);
  assign w_sensor  = temp_valid && (temp_value == '0 || temp_value == '1);
  assign w_over    = temp_valid && w_cfg && (temp_value >= max_temp);
  assign w_restart = (r_state != ST_HEATING);

  bed_runaway_monitor #(
    .SAMPLES (RUNAWAY_SAMPLES),
    .DELTA   (RUNAWAY_DELTA)
  ) u_runaway (
    .clk        (clk),
    .reset      (reset),
    .restart    (w_restart),
    .temp_valid (temp_valid),
    .temp_value (temp_value),
    .runaway    (w_runaway)
  );

  always_comb begin
    w_cause = FAULT_NONE;
    if (w_sensor)
      w_cause = FAULT_SENSOR;
    else if (w_over)
      w_cause = FAULT_OVERTEMP;
    else if (r_state == ST_HEATING && w_runaway)
      w_cause = FAULT_RUNAWAY;
    else if (!temp_valid && r_wd == WD_W'(SAMPLE_TIMEOUT))
      w_cause = FAULT_TIMEOUT;
  end

  always_comb begin
    w_state_n  = r_state;
    w_heater_n = r_heater;
    w_code_n   = r_code;
    w_at_n     = r_at;
    w_wd_n     = r_wd;
    unique case (r_state)
      ST_IDLE: begin
        w_heater_n = 1'b0;
        w_at_n     = 1'b0;
        w_wd_n     = '0;
        if (w_over) begin
          w_state_n = ST_FAULT;
          w_code_n  = FAULT_OVERTEMP;
        end else if (enable && w_cfg) begin
          w_state_n  = ST_HEATING;
          w_heater_n = 1'b1;
        end
      end
      ST_HEATING, ST_HOLDING: begin
        w_wd_n = temp_valid ? '0 : r_wd + WD_W'(1);
        if (w_cause != FAULT_NONE) begin
          w_state_n  = ST_FAULT;
          w_code_n   = w_cause;
          w_heater_n = 1'b0;
          w_at_n     = 1'b0;
          w_wd_n     = '0;
        end else if (!enable || !w_cfg) begin
          w_state_n  = ST_IDLE;
          w_heater_n = 1'b0;
          w_at_n     = 1'b0;
          w_wd_n     = '0;
        end else if (r_state == ST_HEATING) begin
          w_heater_n = 1'b1;
          if (temp_valid && temp_value >= w_tgt_eff) begin
            w_state_n  = ST_HOLDING;
            w_heater_n = 1'b0;
            w_at_n     = 1'b1;
          end
        end else if (temp_valid) begin
          // Between lo and target the heater keeps its last drive
          if (temp_value >= w_tgt_eff)
            w_heater_n = 1'b0;
          else if (temp_value < w_lo)
            w_heater_n = 1'b1;
          w_at_n = (temp_value >= w_lo);
        end
      end
      ST_FAULT: begin
        w_heater_n = 1'b0;
        w_at_n     = 1'b0;
        w_wd_n     = '0;
        if (fault_clear && !enable) begin
          w_state_n = ST_IDLE;
          w_code_n  = FAULT_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_heater <= 1'b0;
      r_fault  <= 1'b0;
      r_code   <= FAULT_NONE;
      r_at     <= 1'b0;
      r_wd     <= '0;
    end else begin
      r_state  <= w_state_n;
      r_heater <= w_heater_n;
      r_fault  <= (w_state_n == ST_FAULT);
      r_code   <= w_code_n;
      r_at     <= w_at_n;
      r_wd     <= w_wd_n;
    end
  end

  assign heater_on  = r_heater;
  assign fault      = r_fault;
  assign fault_code = r_code;
  assign state      = r_state;
  assign at_target  = r_at;

endmodule

// File: tb/tb_bed_thermal_guard.sv
// Directed bench for bed_thermal_guard with short timeout and
// runaway window so every protection path is reachable quickly.
module tb_bed_thermal_guard;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] max_temp;
  logic [11:0] target_temp;
  logic        enable;
  logic        fault_clear;
  logic        temp_valid;
  logic [11:0] temp_value;
  logic        heater_on;
  logic        fault;
  logic [2:0]  fault_code;
  logic [1:0]  state;
  logic        at_target;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bed_thermal_guard #(
    .SAMPLE_TIMEOUT  (100),
    .HYST            (4),
    .RUNAWAY_SAMPLES (4),
    .RUNAWAY_DELTA   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .max_temp    (max_temp),
    .target_temp (target_temp),
    .enable      (enable),
    .fault_clear (fault_clear),
    .temp_valid  (temp_valid),
    .temp_value  (temp_value),
    .heater_on   (heater_on),
    .fault       (fault),
    .fault_code  (fault_code),
    .state       (state),
    .at_target   (at_target)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    fault_clear = 1'b0;
    temp_valid = 1'b0;
    temp_value = 12'd0;
    tick();
    reset = 1'b0;
  endtask

  task automatic sample(input logic [11:0] v);
    temp_valid = 1'b1;
    temp_value = v;
    tick();
    temp_valid = 1'b0;
  endtask

  task automatic go_heat();
    enable = 1'b1;
    tick();
  endtask

  task automatic clear_fault();
    enable = 1'b0;
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
  endtask

  // Compact observation vector: {state, heater_on, fault, fault_code}
  function automatic logic [6:0] obs();
    return {state, heater_on, fault, fault_code};
  endfunction

  task automatic test_reset();
    max_temp = 12'd400;
    target_temp = 12'd300;
    do_reset();
    checks++;
    if (obs() !== 7'b00_0_0_000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b", obs(), 7'b0);
    end
    checks++;
    if (at_target !== 1'b0) begin
      errors++;
      $display("FAIL reset_at_target got %b exp 0", at_target);
    end
  endtask

  task automatic test_ramp_hold();
    do_reset();
    max_temp = 12'd400;
    target_temp = 12'd300;
    go_heat();
    checks++;
    if (obs() !== {2'd1, 1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL ramp_enter got %b exp %b", obs(), {2'd1, 5'b10000});
    end
    for (int i = 0; i < 40; i++) begin
      sample(12'(100 + 5 * i));
      checks++;
      if ({state, heater_on} !== {2'd1, 1'b1}) begin
        errors++;
        $display("FAIL ramp_step%0d got %b exp 011", i, {state, heater_on});
      end
    end
    sample(12'd300);
    checks++;
    if ({state, heater_on, at_target} !== {2'd2, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL hold_enter got %b exp 1001", {state, heater_on, at_target});
    end
    sample(12'd298);
    checks++;
    if ({heater_on, at_target} !== 2'b01) begin
      errors++;
      $display("FAIL hold_298 got %b exp 01", {heater_on, at_target});
    end
    sample(12'd295);
    checks++;
    if ({heater_on, at_target} !== 2'b10) begin
      errors++;
      $display("FAIL hold_295 got %b exp 10", {heater_on, at_target});
    end
    sample(12'd299);
    checks++;
    if ({heater_on, at_target} !== 2'b11) begin
      errors++;
      $display("FAIL hold_299 got %b exp 11", {heater_on, at_target});
    end
    sample(12'd300);
    checks++;
    if ({state, heater_on, fault} !== {2'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL hold_300 got %b exp 1000", {state, heater_on, fault});
    end
  endtask

  task automatic test_overtemp_clamp();
    do_reset();
    max_temp = 12'd400;
    target_temp = 12'd500;
    go_heat();
    sample(12'd399);
    checks++;
    if ({state, heater_on} !== {2'd2, 1'b0}) begin
      errors++;
      $display("FAIL clamp_399 got %b exp 100", {state, heater_on});
    end
    sample(12'd400);
    checks++;
    if (obs() !== {2'd3, 1'b0, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL overtemp got %b exp 1101001", obs());
    end
    fault_clear = 1'b1;
    tick();
    tick();
    checks++;
    if (obs() !== {2'd3, 1'b0, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL clear_enabled got %b exp 1101001", obs());
    end
    enable = 1'b0;
    tick();
    fault_clear = 1'b0;
    checks++;
    if (obs() !== 7'b0) begin
      errors++;
      $display("FAIL clear_ok got %b exp 0000000", obs());
    end
  endtask

  task automatic test_sensor();
    do_reset();
    max_temp = 12'd400;
    target_temp = 12'd300;
    go_heat();
    sample(12'hFFF);
    checks++;
    if (obs() !== {2'd3, 1'b0, 1'b1, 3'd2}) begin
      errors++;
      $display("FAIL sensor_fff got %b exp 1101010", obs());
    end
    clear_fault();
    go_heat();
    sample(12'h000);
    checks++;
    if (obs() !== {2'd3, 1'b0, 1'b1, 3'd2}) begin
      errors++;
      $display("FAIL sensor_000 got %b exp 1101010", obs());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    max_temp = 12'd400;
    target_temp = 12'd300;
    go_heat();
    repeat (100) tick();
    checks++;
    if ({state, fault} !== {2'd1, 1'b0}) begin
      errors++;
      $display("FAIL wd_at_tc got %b exp 010", {state, fault});
    end
    sample(12'd150);
    checks++;
    if ({state, fault} !== {2'd1, 1'b0}) begin
      errors++;
      $display("FAIL wd_sample_wins got %b exp 010", {state, fault});
    end
    repeat (100) tick();
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL wd_early got %b exp 0", fault);
    end
    tick();
    checks++;
    if (obs() !== {2'd3, 1'b0, 1'b1, 3'd3}) begin
      errors++;
      $display("FAIL wd_timeout got %b exp 1101011", obs());
    end
    clear_fault();
    go_heat();
    for (int i = 0; i < 5; i++) begin
      repeat (98) tick();
      sample(12'(100 + 5 * i));
    end
    checks++;
    if ({state, fault} !== {2'd1, 1'b0}) begin
      errors++;
      $display("FAIL wd_periodic got %b exp 010", {state, fault});
    end
  endtask

  task automatic test_runaway();
    do_reset();
    max_temp = 12'd400;
    target_temp = 12'd300;
    go_heat();
    sample(12'd100);
    sample(12'd100);
    sample(12'd101);
    checks++;
    if ({state, fault} !== {2'd1, 1'b0}) begin
      errors++;
      $display("FAIL runaway_mid got %b exp 010", {state, fault});
    end
    sample(12'd101);
    checks++;
    if (obs() !== {2'd3, 1'b0, 1'b1, 3'd4}) begin
      errors++;
      $display("FAIL runaway got %b exp 1101100", obs());
    end
    clear_fault();
    go_heat();
    sample(12'd100);
    sample(12'd101);
    sample(12'd101);
    sample(12'd102);
    checks++;
    if ({state, heater_on, fault} !== {2'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL runaway_ok got %b exp 0110", {state, heater_on, fault});
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    max_temp = 12'd400;
    target_temp = 12'd300;
    go_heat();
    enable = 1'b0;
    sample(12'hFFF);
    checks++;
    if (obs() !== {2'd3, 1'b0, 1'b1, 3'd2}) begin
      errors++;
      $display("FAIL drop_vs_fault got %b exp 1101010", obs());
    end
    clear_fault();
    go_heat();
    enable = 1'b0;
    tick();
    checks++;
    if (obs() !== 7'b0) begin
      errors++;
      $display("FAIL drop_idle got %b exp 0000000", obs());
    end
    sample(12'd450);
    checks++;
    if (obs() !== {2'd3, 1'b0, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL idle_overtemp got %b exp 1101001", obs());
    end
  endtask

  task automatic test_max_zero();
    do_reset();
    max_temp = 12'd0;
    target_temp = 12'd300;
    enable = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs() !== 7'b0) begin
      errors++;
      $display("FAIL max_zero got %b exp 0000000", obs());
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    max_temp = 12'd400;
    target_temp = 12'd300;
    go_heat();
    sample(12'd300);
    sample(12'd290);
    checks++;
    if ({state, heater_on} !== {2'd2, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset got %b exp 101", {state, heater_on});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({obs(), at_target} !== 8'b0) begin
      errors++;
      $display("FAIL reset_mid got %b exp 00000000", {obs(), at_target});
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    fault_clear = 1'b0;
    temp_valid = 1'b0;
    temp_value = 12'd0;
    max_temp = 12'd0;
    target_temp = 12'd0;
    test_reset();
    test_ramp_hold();
    test_overtemp_clamp();
    test_sensor();
    test_timeout();
    test_runaway();
    test_enable_drop();
    test_max_zero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
